// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the sequential RV32M multiplier.
//   - mul_op_e    : 2-bit op encodings (MUL / MULH / MULHSU / MULHU)
//   - mul_state_e : multiplier FSM state encodings
//   - MUL_STEPS   : number of shift-and-add iterations
//   - mag32()     : two's-complement magnitude of a 32-bit operand
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_SIGN = 2'b10,
    S_DONE = 2'b11
  } mul_state_e;

  localparam int MUL_STEPS = 32;

  // Magnitude of v when interpreted as signed (sgn=1), else v itself.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ShiftL64U.sv
// ShiftL64U: shared 64-bit logical left shifter.
// Ports:
//   n   in  8   shift amount; amounts of 64 or more yield zero
//   in  in  64  value to shift
//   out out 64  in << n
module ShiftL64U (
  input  logic [7:0]  n,
  input  logic [63:0] in,
  output logic [63:0] out
);

  assign out = (n >= 8'd64) ? 64'd0 : (in << n[5:0]);

endmodule

// File: rtl/mul_seq_u64.sv
// mul_seq_u64: sequential 32x32->64 shift-and-add multiplier for RV32M
// MUL/MULH/MULHSU/MULHU. Operands are reduced to magnitudes, multiplied
// unsigned over up to 32 iterations, and the sign is applied at the end.
//
// Optional build macro: MULSEQ_EARLY_TERM_EN
//   defined   : leave CALC as soon as no multiplier bits remain
//   undefined : always 32 CALC cycles (results are identical either way)
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operation presented
//   in_ready   out  1   idle, can accept (registered)
//   op         in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1        in   32  multiplicand
//   rs2        in   32  multiplier
//   out_valid  out  1   result valid (registered)
//   out_ready  in   1   consumer takes result
//   rd         out  32  product[31:0] for MUL, product[63:32] otherwise
//   busy       out  1   computing (CALC or SIGN)
module mul_seq_u64
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rd,
  output logic        busy
);

  mul_state_e  state;
  mul_op_e     op_q;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        neg;
  logic [63:0] acc;
  logic [5:0]  step;

  logic        rs1_signed;
  logic        rs2_signed;
  logic        neg_in;
  logic [63:0] pp;
  logic [63:0] acc_fixed;
  logic        calc_last;
  logic        mplier_done;

  // NOTE: every always_comb output gets a value on every path (here,
  // unconditionally) so no latch can be inferred.
  always_comb begin
    rs1_signed = (mul_op_e'(op) == MUL_OP_MULH) || (mul_op_e'(op) == MUL_OP_MULHSU);
    rs2_signed = (mul_op_e'(op) == MUL_OP_MULH);
    neg_in     = (rs1_signed & rs1[31]) ^ (rs2_signed & rs2[31]);
    acc_fixed  = neg ? (~acc + 64'd1) : acc;
    calc_last  = (step == 6'(MUL_STEPS - 1));
  end

`ifdef MULSEQ_EARLY_TERM_EN
  // No remaining multiplier bits means no further partial products.
  assign mplier_done = ((mplier >> step) == 32'd0);
`else
  assign mplier_done = 1'b0;
`endif

  ShiftL64U u_shift (
    .n   ({2'b00, step}),
    .in  ({32'd0, mcand}),
    .out (pp)
  );

  // Single FSM; in_ready/out_valid/busy are registered so nothing on the
  // result side reaches in_ready combinationally.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= MUL_OP_MUL;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      step      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rd        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= mul_op_e'(op);
            mcand    <= mag32(rs1, rs1_signed);
            mplier   <= mag32(rs2, rs2_signed);
            neg      <= neg_in;
            acc      <= '0;
            step     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_CALC: begin
          if (mplier_done) begin
            state <= S_SIGN;
          end else begin
            if (mplier[step[4:0]]) acc <= acc + pp;
            step <= step + 6'd1;
            if (calc_last) state <= S_SIGN;
          end
        end
        S_SIGN: begin
          acc       <= acc_fixed;
          rd        <= (op_q == MUL_OP_MUL) ? acc_fixed[31:0] : acc_fixed[63:32];
          busy      <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
